// File: rtl/ad9952_pkg.sv
// +--------------------------------------------------------------------------+
// | ad9952_pkg : AD9952 register map, per-register lengths, instruction bits |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package ad9952_pkg;

  localparam logic [4:0] CFR1 = 5'd0;
  localparam logic [4:0] CFR2 = 5'd1;
  localparam logic [4:0] ASF  = 5'd2;
  localparam logic [4:0] ARR  = 5'd3;
  localparam logic [4:0] FTW0 = 5'd4;
  localparam logic [4:0] POW0 = 5'd5;

  localparam int READ_BIT = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] len;
  } reg_len_t;

  function automatic reg_len_t reg_len(input logic [4:0] addr);
    reg_len_t r;
    r.valid = 1'b1;
    r.len   = 3'd0;
    case (addr)
      CFR1:    r.len = 3'd4;
      CFR2:    r.len = 3'd3;
      ASF:     r.len = 3'd2;
      ARR:     r.len = 3'd1;
      FTW0:    r.len = 3'd4;
      POW0:    r.len = 3'd2;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dds_rd_collector.sv
// +--------------------------------------------------------------------------+
// | dds_rd_collector : gathers MISO bytes of a read frame into rd_data       |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module dds_rd_collector (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        active,
  input  logic [2:0]  len,
  input  logic        gap_done,
  input  logic [7:0]  miso_byte,
  input  logic        miso_wrreq,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err
);

  logic [2:0] rx_cnt;
  logic [2:0] rx_nx;
  logic       take;

  assign take  = active && miso_wrreq && (rx_cnt < len);
  assign rx_nx = take ? rx_cnt + 3'd1 : rx_cnt;

  // Byte 0 arrives while the instruction is shifted out and carries no data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_cnt   <= 3'd0;
      rd_data  <= 32'd0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= take && (rx_nx == len);
      rd_err   <= active && gap_done && (rx_nx < len);
      if (start) begin
        rx_cnt  <= 3'd0;
        rd_data <= 32'd0;
      end else if (take) begin
        rx_cnt <= rx_nx;
        if (rx_cnt != 3'd0)
          rd_data <= {rd_data[23:0], miso_byte};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dds_cmd_framer.sv
// +--------------------------------------------------------------------------+
// | dds_cmd_framer : register command -> SPI byte frame with inter-frame gap |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module dds_cmd_framer
  import ad9952_pkg::*;
#(
  parameter int CLK_DIV_EVEN = 8,
  parameter int GAP_CYCLES   = 10 * CLK_DIV_EVEN
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        have_data,
  output logic [7:0]  data_o,
  input  logic        rdreq,
  input  logic [7:0]  miso_byte,
  input  logic        miso_wrreq,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err,
  output logic        err_addr
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (GAP_CYCLES < 9 * CLK_DIV_EVEN) begin : g_gap_check
    $error("GAP_CYCLES too short for the SPI master to release n_cs");
  end

  state_t      state, state_nx;
  logic [7:0]  frame_buf [0:7];
  logic [2:0]  idx;
  logic [2:0]  len;
  logic [GW-1:0] gap_cnt;
  logic        is_read;
  logic        accept;
  logic        last_pop;
  logic        gap_done;
  reg_len_t    cmd_len;
  logic [7:0]  instr;
  logic [5:0]  wshamt;
  logic [31:0] wdata;

  assign cmd_len = reg_len(cmd_addr);

  // Left-justify the write value so bytes 1..L are always wdata[31:24] onward.
  assign wshamt = {3'd4 - cmd_len.len, 3'b000};
  assign wdata  = cmd_read ? 32'd0 : (cmd_data << wshamt);

  always_comb begin
    instr           = {3'b000, cmd_addr};
    instr[READ_BIT] = cmd_read;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    have_data = 1'b0;
    accept    = 1'b0;
    last_pop  = 1'b0;
    gap_done  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_len.valid) begin
          accept   = 1'b1;
          state_nx = S_SEND;
        end
      end
      S_SEND: begin
        have_data = 1'b1;
        if (rdreq && (idx == len - 3'd1)) begin
          last_pop = 1'b1;
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          gap_done = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign data_o = have_data ? frame_buf[idx] : 8'h00;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 8; i++) frame_buf[i] <= 8'h00;
      idx      <= 3'd0;
      len      <= 3'd0;
      gap_cnt  <= '0;
      is_read  <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      err_addr <= (state == S_IDLE) && cmd_valid && !cmd_len.valid;
      if (accept) begin
        frame_buf[0] <= instr;
        frame_buf[1] <= wdata[31:24];
        frame_buf[2] <= wdata[23:16];
        frame_buf[3] <= wdata[15:8];
        frame_buf[4] <= wdata[7:0];
        frame_buf[5] <= 8'h00;
        frame_buf[6] <= 8'h00;
        frame_buf[7] <= 8'h00;
        len     <= cmd_len.len + 3'd1;
        idx     <= 3'd0;
        is_read <= cmd_read;
      end else if ((state == S_SEND) && rdreq) begin
        idx <= idx + 3'd1;
      end
      if (last_pop)
        gap_cnt <= '0;
      else if (state == S_GAP)
        gap_cnt <= gap_cnt + GW'(1);
    end
  end

  dds_rd_collector u_rd_collector (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (accept),
    .active     (is_read && (state != S_IDLE)),
    .len        (len),
    .gap_done   (gap_done),
    .miso_byte  (miso_byte),
    .miso_wrreq (miso_wrreq),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err)
  );

endmodule

`default_nettype wire

// File: tb/tb_dds_cmd_framer.sv
// +--------------------------------------------------------------------------+
// | tb_dds_cmd_framer : scoreboard bench with a behavioural SPI master model |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dds_cmd_framer;

  localparam int CLK_DIV_EVEN = 8;
  localparam int GAP_CYCLES   = 10 * CLK_DIV_EVEN;
  localparam int EV_RDV       = 0;
  localparam int EV_RDERR     = 1;
  localparam int EV_ERRADDR   = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        have_data;
  logic [7:0]  data_o;
  logic        rdreq;
  logic [7:0]  miso_byte;
  logic        miso_wrreq;
  logic [31:0] rd_data;
  logic        rd_valid, rd_err, err_addr;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_bytes[$];
  ev_t        exp_ev[$];

  // SPI master model configuration, written by the stimulus before each frame
  logic [7:0] cfg_miso [6];
  int cfg_budget, cfg_pop_gap, cfg_len;
  int m_pops, m_sched, m_wr_sent, pop_wait;
  int wrq[$];

  int len_tab [6] = '{4, 3, 2, 1, 4, 2};

  always #5 clk = ~clk;

  dds_cmd_framer #(.CLK_DIV_EVEN(CLK_DIV_EVEN), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_read   (cmd_read),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .have_data  (have_data),
    .data_o     (data_o),
    .rdreq      (rdreq),
    .miso_byte  (miso_byte),
    .miso_wrreq (miso_wrreq),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err),
    .err_addr   (err_addr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic got_event(input int kind, input logic [31:0] data, input string nm);
    ev_t e;
    if (exp_ev.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: unexpected pulse (value 0x%0h), no pulse expected", nm, data);
    end else begin
      e = exp_ev.pop_front();
      check({nm, "_kind"}, kind, e.kind);
      if (kind == EV_RDV) check(nm, data, e.data);
    end
  endtask

  function automatic int len_of(input logic [4:0] a);
    return (a < 5'd6) ? len_tab[a] : 0;
  endfunction

  // Monitor: compares every popped byte and every output pulse against the queues.
  always begin
    @(negedge clk);
    #1;
    if (n_rst) begin
      if (rdreq && have_data) begin
        if (exp_bytes.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL frame_byte: unexpected byte 0x%0h, none expected", data_o);
        end else begin
          check("frame_byte", data_o, exp_bytes.pop_front());
        end
      end
      if (rd_valid) got_event(EV_RDV, rd_data, "rd_valid");
      if (rd_err)   got_event(EV_RDERR, 0, "rd_err");
      if (err_addr) got_event(EV_ERRADDR, 0, "err_addr");
    end
  end

  // SPI master model: pops a byte every cfg_pop_gap+1 cycles, returns a MISO
  // byte two cycles after each pop, plus stray pops outside a frame.
  always begin
    @(negedge clk);
    rdreq      = 1'b0;
    miso_wrreq = 1'b0;
    if (!n_rst) begin
      wrq.delete();
    end else begin
      for (int i = 0; i < wrq.size(); i++) wrq[i] = wrq[i] - 1;
      if (wrq.size() > 0 && wrq[0] <= 0) begin
        void'(wrq.pop_front());
        miso_wrreq = 1'b1;
        miso_byte  = cfg_miso[m_wr_sent];
        m_wr_sent++;
      end
      if (have_data) begin
        if (pop_wait == 0) begin
          rdreq = 1'b1;
          m_pops++;
          pop_wait = cfg_pop_gap;
          if (m_sched < cfg_budget) begin wrq.push_back(2); m_sched++; end
          if (m_pops == cfg_len && m_sched < cfg_budget) begin wrq.push_back(6); m_sched++; end
        end else begin
          pop_wait--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        rdreq = 1'b1;
      end
    end
  end

  task automatic setup_frame(input logic rd, input logic [4:0] a, input logic [31:0] d,
                             input int budget, input int popg, input logic [47:0] mpack,
                             output int L);
    logic [31:0] acc;
    ev_t e;
    L = len_of(a);
    for (int i = 0; i < 6; i++) cfg_miso[i] = mpack[47-8*i -: 8];
    cfg_len     = L + 1;
    cfg_budget  = rd ? budget : L + 1;
    cfg_pop_gap = popg;
    m_pops = 0; m_sched = 0; m_wr_sent = 0; pop_wait = popg;
    e.data = 32'd0;
    if (L == 0) begin
      e.kind = EV_ERRADDR;
      exp_ev.push_back(e);
    end else begin
      exp_bytes.push_back({rd, 2'b00, a});
      for (int i = 1; i <= L; i++) exp_bytes.push_back(rd ? 8'h00 : 8'(d >> (8 * (L - i))));
      if (rd) begin
        if (budget >= L + 1) begin
          acc = 32'd0;
          for (int i = 1; i <= L; i++) acc = (acc << 8) | 32'(cfg_miso[i]);
          e.kind = EV_RDV;
          e.data = acc;
        end else begin
          e.kind = EV_RDERR;
        end
        exp_ev.push_back(e);
      end
    end
  endtask

  task automatic run_cmd(input logic rd, input logic [4:0] a, input logic [31:0] d,
                         input int budget, input int popg, input bit busy,
                         input logic [47:0] mpack);
    int L, k;
    bit saw_ready;
    setup_frame(rd, a, d, budget, popg, mpack, L);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    if (L == 0) begin
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        check("invalid_addr_idle", {have_data, cmd_ready}, 2'b01);
        @(negedge clk);
      end
      return;
    end
    check("accept_latency", {cmd_ready, have_data}, 2'b01);
    cmd_valid = busy;
    saw_ready = 1'b0;
    k = 0;
    while (have_data && k < 5000) begin
      if (cmd_ready) saw_ready = 1'b1;
      if (busy) begin
        cmd_addr = 5'($urandom_range(0, 7)); cmd_read = 1'($urandom); cmd_data = $urandom;
      end
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    if (busy) check("busy_cmd_ready", 32'(saw_ready), 0);
    check("send_timeout", 32'(k >= 5000), 0);
    check("pops_per_frame", m_pops, L + 1);
    k = 0;
    while (!cmd_ready && k < GAP_CYCLES + 50) begin
      @(negedge clk);
      k++;
    end
    check("gap_cycles", k, GAP_CYCLES);
  endtask

  task automatic reset_mid_send();
    int L, k;
    setup_frame(1'b0, 5'd4, 32'hCAFEF00D, 5, 5, 48'h0, L);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 5'd4; cmd_data = 32'hCAFEF00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (m_pops < 2 && k < 200) begin @(negedge clk); k++; end
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("reset_have_data", 32'(have_data), 0);
    check("reset_cmd_ready", 32'(cmd_ready), 1);
    exp_bytes.delete();
    exp_ev.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  function automatic logic [47:0] rand48();
    return 48'({$urandom(), $urandom()});
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, L, r, budget;
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = 5'd0; cmd_data = 32'd0;
    rdreq = 1'b0; miso_byte = 8'h00; miso_wrreq = 1'b0;
    cfg_budget = 0; cfg_pop_gap = 3; cfg_len = 0;
    m_pops = 0; m_sched = 0; m_wr_sent = 0; pop_wait = 3;
    for (int i = 0; i < 6; i++) cfg_miso[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ready_have", {cmd_ready, have_data}, 2'b10);
    check("reset_pulses", {rd_valid, rd_err, err_addr}, 3'b000);
    check("reset_data", {data_o, rd_data}, 40'd0);
    n_rst = 1'b1;

    run_cmd(1'b0, 5'd4, 32'h12345678, 5, 63, 1'b0, rand48());
    run_cmd(1'b0, 5'd3, 32'hFFFFFFAB, 2, 4, 1'b0, rand48());
    run_cmd(1'b1, 5'd2, 32'hDEADBEEF, 3, 4, 1'b0, 48'hFF3FA5_000000);
    run_cmd(1'b0, 5'd7, 32'h0, 0, 4, 1'b0, rand48());
    run_cmd(1'b1, 5'd1, $urandom, 2, 4, 1'b0, rand48());
    run_cmd(1'b1, 5'd0, $urandom, 6, 3, 1'b1, rand48());
    reset_mid_send();
    run_cmd(1'b0, 5'd5, 32'h0000BEEF, 3, 3, 1'b0, rand48());

    repeat (40) begin
      a = $urandom_range(0, 7);
      L = len_of(5'(a));
      r = $urandom_range(0, 3);
      budget = (r == 0) ? $urandom_range(0, L) : (r == 1) ? L + 2 : L + 1;
      run_cmd(1'($urandom), 5'(a), $urandom, budget, $urandom_range(3, 10),
              ($urandom_range(0, 3) == 0), rand48());
    end

    repeat (10) @(negedge clk);
    check("bytes_drained", exp_bytes.size(), 0);
    check("events_drained", exp_ev.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dds_cmd_framer.md
Name: dds_cmd_framer

Overview:
- Upstream stage of the AD9952 SPI master. Turns one register-access command into a byte frame:
  - instruction byte, then 1-4 data or dummy bytes.
- Presents the frame on the master's have_data/data_i/rdreq byte interface. Holds a guard gap after each frame so the master deasserts n_cs between frames.
- Collects the master's miso_reg/wrreq bytes for read frames and returns the right-justified register value.

Parameters:
- CLK_DIV_EVEN, 8, divider used by the SPI master (sclk period in clk cycles).
- GAP_CYCLES, 10*CLK_DIV_EVEN, clk cycles held idle after the last byte is popped; must be >= 9*CLK_DIV_EVEN.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  framer can accept a command
- cmd_read  in  1  1=read, 0=write
- cmd_addr  in  5  AD9952 register address
- cmd_data  in  32  write value, right-justified; ignored on read
- have_data  out  1  byte available to SPI master
- data_o  out  8  current byte (show-ahead)
- rdreq  in  1  SPI master pop strobe
- miso_byte  in  8  SPI master miso_reg
- miso_wrreq  in  1  SPI master wrreq (byte received)
- rd_data  out  32  read value, right-justified
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_err  out  1  one-cycle pulse, read frame ended incomplete
- err_addr  out  1  one-cycle pulse, command had invalid address

Behaviour:
- Reset: asynchronous, active-low. All outputs 0 except cmd_ready=1; state IDLE; frame buffer, index and counters cleared. A reset mid-frame abandons the frame; the SPI master shares n_rst.
- Register length L by address: 0→4, 1→3, 2→2, 3→1, 4→4, 5→2. Any other address is invalid.
- States:
  - IDLE: cmd_ready=1, have_data=0.
    - cmd_valid with invalid address → err_addr pulses next cycle; stay IDLE.
    - cmd_valid with valid address → next cycle:
      - byte0 = {cmd_read, 2'b00, cmd_addr}.
      - bytes 1..L = cmd_data[8L-1:0], MSB first (write), or 0x00 (read).
      - len=L+1, idx=0, rx_cnt=0, rd_data=0; go to SEND.
  - SEND: cmd_ready=0, have_data=1, data_o=buf[idx].
    - rdreq → idx+1.
    - rdreq with idx==len-1 → go to GAP next cycle; have_data drops that same cycle; gap_cnt=0.
  - GAP: cmd_ready=0, have_data=0.
    - gap_cnt increments each cycle; at gap_cnt==GAP_CYCLES-1 → IDLE.
    - On that exit cycle, a read frame with rx_cnt<len pulses rd_err.
- rdreq outside SEND is ignored.
- Read collection (read frames, SEND or GAP only):
  - Each miso_wrreq increments rx_cnt.
  - The first byte (instruction slot) is discarded.
  - Later bytes: rd_data <= {rd_data[23:0], miso_byte}.
  - rd_valid pulses the cycle after the wrreq that makes rx_cnt==len. rd_data then holds its value until the next read frame starts.
- miso_wrreq during write frames or in IDLE is ignored.
- Extra wrreqs beyond len in the same frame are ignored.
- Write-frame behaviour: cmd_data bits above 8L are dropped silently.
- Latency: have_data rises 1 cycle after a command is accepted. Frame-to-frame throughput is one frame per (len*8*CLK_DIV_EVEN + GAP_CYCLES) cycles, approximately.
- Counters: idx 3 bits, rx_cnt 3 bits, gap_cnt wide enough for GAP_CYCLES; no wrap is possible.

Decomposition:
- Shared package (ad9952_pkg):
  - register address constants CFR1=0, CFR2=1, ASF=2, ARR=3, FTW0=4, POW0=5;
  - length function addr→L plus valid flag;
  - instruction-byte read bit position 7.
- One sub-module is natural: dds_rd_collector (rx_cnt, shift register, rd_valid/rd_err generation). Frame buffer and FSM stay in the top.

Test Plan:
- Write FTW0: addr=4, data=0x12345678, model master pops every 64 cycles → data_o sequence 0x04,0x12,0x34,0x56,0x78. have_data drops the cycle after the 5th rdreq. cmd_ready returns exactly GAP_CYCLES cycles later.
- Write ARR: addr=3, data=0xFFFFFFAB → exactly 2 bytes 0x03,0xAB; no rd_valid.
- Read ASF: addr=2, cmd_read=1 → bytes 0x82,0x00,0x00. Supply miso_wrreq bytes 0xFF,0x3F,0xA5 → single rd_valid with rd_data=0x00003FA5; no rd_err.
- Invalid address 7 → err_addr high exactly one cycle; have_data stays 0; cmd_ready stays 1.
- Read CFR2 (addr=1) with only 2 wrreqs supplied → no rd_valid; rd_err pulses once on the GAP→IDLE cycle.
- Busy and reset checks:
  - cmd_valid held during SEND/GAP → not accepted; cmd_ready=0.
  - n_rst low mid-SEND → have_data=0 and cmd_ready=1 immediately.
  - After release, a new command frames correctly from byte0.
